// File: rtl/mem_bus_master.sv
// Single-transaction MIPS load/store initiator for a 32-bit word-addressed memory bus.
// Define MEM_BUS_MISALIGN_TRAP_EN to complete misaligned half/word accesses as errors.
module mem_bus_master #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_op,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDATA, S_DONE} state_t;

  localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_bad;
  logic        is_store;

  function automatic logic op_valid(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1011: op_valid = 1'b1;
      default:                   op_valid = 1'b0;
    endcase
  endfunction

`ifdef MEM_BUS_MISALIGN_TRAP_EN
  // op[1:0] encodes access size for both loads and stores: 00 byte, 01 half, 11 word.
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op[1:0])
      2'b01:   misaligned = a[0];
      2'b11:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction
`endif

  function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] a,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op[1:0])
      2'b00:   load_extend = op[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_extend = op[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extend = rd;
    endcase
  endfunction

  function automatic logic [3:0] lane_enable(input logic [3:0] op, input logic [1:0] a);
    if (!op[3])
      lane_enable = 4'b1111;
    else begin
      case (op[1:0])
        2'b00:   lane_enable = 4'b0001 << a;
        2'b01:   lane_enable = a[1] ? 4'b1100 : 4'b0011;
        default: lane_enable = 4'b1111;
      endcase
    end
  endfunction

  function automatic logic [31:0] lane_data(input logic [3:0] op, input logic [31:0] w);
    case (op[1:0])
      2'b00:   lane_data = {4{w[7:0]}};
      2'b01:   lane_data = {2{w[15:0]}};
      default: lane_data = w;
    endcase
  endfunction

`ifdef MEM_BUS_MISALIGN_TRAP_EN
  assign req_bad = !op_valid(cpu_op) || misaligned(cpu_op, cpu_addr[1:0]);
`else
  assign req_bad = !op_valid(cpu_op);
`endif

  assign is_store = op_q[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          op_d    = cpu_op;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          err_d   = req_bad;
          state_d = req_bad ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!waitrequest) begin
          cnt_d   = LAT_M1;
          state_d = is_store ? S_DONE : S_RDATA;
        end
      end
      S_RDATA: begin
        // Capture edge is READ_LATENCY edges after accept.
        if (cnt_q == 2'd0) begin
          rdata_d = load_extend(op_q, addr_q[1:0], readdata);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cpu_busy   = (state_q != S_IDLE);
  assign cpu_done   = (state_q == S_DONE);
  assign cpu_err    = (state_q == S_DONE) && err_q;
  assign cpu_rdata  = rdata_q;
  assign read       = (state_q == S_ISSUE) && !is_store;
  assign write      = (state_q == S_ISSUE) && is_store;
  assign address    = (state_q == S_ISSUE) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign byteenable = (state_q == S_ISSUE) ? lane_enable(op_q, addr_q[1:0]) : 4'd0;
  assign writedata  = write ? lane_data(op_q, wdata_q) : 32'd0;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a cycle-stepped slave model (READ_LATENCY=2).
module tb_mem_bus_master;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [3:0]  cpu_op;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_busy, cpu_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic [31:0] address, writedata, readdata;
  logic        write, read, waitrequest;
  logic [3:0]  byteenable;

  mem_bus_master #(.READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_op(cpu_op),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int          n_strb, done_c;
  logic        saw_rd, saw_wr, stable, busy_ok, post_ok, err_r;
  logic [31:0] a0, wd0, rd_r;
  logic [3:0]  be0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request; slave stalls the first nwait strobe cycles and presents rdval
  // only in the cycle whose closing edge is READ_LATENCY edges after accept.
  task automatic xact(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdval, input int nwait, input bit noise);
    int acc;
    acc = 0; n_strb = 0; done_c = -1; saw_rd = 0; saw_wr = 0; stable = 1;
    busy_ok = 1; post_ok = 0; err_r = 0; rd_r = 0; a0 = 0; wd0 = 0; be0 = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_op = op; cpu_addr = addr; cpu_wdata = wdata; waitrequest = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      cpu_req = noise;
      if (noise) begin
        cpu_op = 4'b1011; cpu_addr = 32'h0000_0F00; cpu_wdata = 32'h1111_2222;
      end
      if (read || write) begin
        n_strb++;
        if (n_strb == 1) begin
          a0 = address; be0 = byteenable; wd0 = writedata;
        end else if (address !== a0 || byteenable !== be0 || writedata !== wd0) begin
          stable = 0;
        end
        saw_rd |= read;
        saw_wr |= write;
        waitrequest = (n_strb <= nwait);
        if (!waitrequest) acc = c;
      end else begin
        waitrequest = 1'b0;
      end
      readdata = (acc > 0 && c == acc + RL) ? rdval : (32'h5A5A_0000 | 32'(c));
      if (!cpu_busy) busy_ok = 0;
      if (cpu_done) begin
        done_c = c; err_r = cpu_err; rd_r = cpu_rdata; cpu_req = 1'b0;
        break;
      end
    end
    cpu_req = 1'b0;
    @(negedge clk);
    post_ok = !cpu_done && !cpu_busy && !read && !write;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_op = 4'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    waitrequest = 1'b0; readdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy_done_err", {29'd0, cpu_busy, cpu_done, cpu_err}, 32'd0);
    check_eq("rst_strobes", {30'd0, read, write}, 32'd0);
    check_eq("rst_address", address, 32'd0);
    check_eq("rst_be_wdata", {28'd0, byteenable} | writedata, 32'd0);
    check_eq("rst_rdata", cpu_rdata, 32'd0);

    xact(4'b1011, 32'h0000_0104, 32'hDEAD_BEEF, 32'd0, 0, 0);
    check_eq("sw_strobe", {n_strb[29:0], saw_rd, saw_wr}, {30'd1, 1'b0, 1'b1});
    check_eq("sw_addr", a0, 32'h0000_0104);
    check_eq("sw_be", {28'd0, be0}, 32'hF);
    check_eq("sw_wdata", wd0, 32'hDEAD_BEEF);
    check_eq("sw_done_cycle", done_c, 2);
    check_eq("sw_err", {31'd0, err_r}, 32'd0);
    check_eq("sw_post_idle", {31'd0, post_ok}, 32'd1);
    check_eq("sw_busy", {31'd0, busy_ok}, 32'd1);

    xact(4'b1000, 32'h0000_0107, 32'h0000_00A5, 32'd0, 0, 0);
    check_eq("sb_be", {28'd0, be0}, 32'h8);
    check_eq("sb_wdata", wd0, 32'hA5A5_A5A5);
    check_eq("sb_addr", a0, 32'h0000_0104);
    check_eq("sb_done_cycle", done_c, 2);

    xact(4'b0100, 32'h0000_0107, 32'd0, 32'hA500_0000, 0, 0);
    check_eq("lbu_rdata", rd_r, 32'h0000_00A5);
    check_eq("lbu_read", {n_strb[30:0], saw_rd}, {31'd1, 1'b1});
    check_eq("lbu_be", {28'd0, be0}, 32'hF);
    check_eq("lbu_done_cycle", done_c, 2 + RL);
    check_eq("lbu_wdata_zero", wd0, 32'd0);

    xact(4'b0000, 32'h0000_0107, 32'd0, 32'hA500_0000, 0, 0);
    check_eq("lb_rdata", rd_r, 32'hFFFF_FFA5);

    xact(4'b0001, 32'h0000_0102, 32'd0, 32'h8001_1234, 0, 0);
    check_eq("lh_hi_rdata", rd_r, 32'hFFFF_8001);
    check_eq("lh_addr", a0, 32'h0000_0100);
    xact(4'b0101, 32'h0000_0102, 32'd0, 32'h8001_1234, 0, 0);
    check_eq("lhu_hi_rdata", rd_r, 32'h0000_8001);
    xact(4'b0001, 32'h0000_0100, 32'd0, 32'h8001_1234, 0, 0);
    check_eq("lh_lo_rdata", rd_r, 32'h0000_1234);

    xact(4'b1001, 32'h0000_0106, 32'h0000_BEEF, 32'd0, 0, 0);
    check_eq("sh_be", {28'd0, be0}, 32'hC);
    check_eq("sh_wdata", wd0, 32'hBEEF_BEEF);
    check_eq("store_keeps_rdata", rd_r, 32'h0000_1234);

    xact(4'b0011, 32'h0000_0208, 32'd0, 32'h1357_9BDF, 3, 1);
    check_eq("lw_wait_strobes", n_strb, 4);
    check_eq("lw_wait_stable", {31'd0, stable}, 32'd1);
    check_eq("lw_wait_addr", a0, 32'h0000_0208);
    check_eq("lw_wait_rdata", rd_r, 32'h1357_9BDF);
    check_eq("lw_wait_done_cycle", done_c, 4 + RL + 1);
    check_eq("lw_wait_noise_ignored", {31'd0, post_ok}, 32'd1);
    check_eq("lw_wait_busy", {31'd0, busy_ok}, 32'd1);

    xact(4'b0111, 32'h0000_0100, 32'd0, 32'd0, 0, 0);
    check_eq("bad_op_err", {31'd0, err_r}, 32'd1);
    check_eq("bad_op_done_cycle", done_c, 1);
    check_eq("bad_op_no_strobe", n_strb, 0);
    check_eq("bad_op_keeps_rdata", rd_r, 32'h1357_9BDF);

    xact(4'b0011, 32'h0000_0102, 32'd0, 32'hCAFE_F00D, 0, 0);
`ifdef MEM_BUS_MISALIGN_TRAP_EN
    check_eq("lw_mis_err", {31'd0, err_r}, 32'd1);
    check_eq("lw_mis_no_strobe", n_strb, 0);
    check_eq("lw_mis_done_cycle", done_c, 1);
`else
    check_eq("lw_mis_err", {31'd0, err_r}, 32'd0);
    check_eq("lw_mis_addr", a0, 32'h0000_0100);
    check_eq("lw_mis_rdata", rd_r, 32'hCAFE_F00D);
    check_eq("lw_mis_done_cycle", done_c, 2 + RL);
`endif

    // Abandon a stalled read with reset.
    @(negedge clk);
    cpu_req = 1'b1; cpu_op = 4'b0011; cpu_addr = 32'h0000_0300;
    @(negedge clk);
    cpu_req = 1'b0; waitrequest = 1'b1;
    @(negedge clk);
    check_eq("pre_rst_read", {31'd0, read}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_read", {31'd0, read}, 32'd0);
    check_eq("mid_rst_busy_done", {30'd0, cpu_busy, cpu_done}, 32'd0);
    check_eq("mid_rst_rdata", cpu_rdata, 32'd0);
    reset = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    check_eq("post_rst_idle", {29'd0, cpu_busy, cpu_done, read}, 32'd0);

    xact(4'b1011, 32'h0000_0010, 32'h0123_4567, 32'd0, 0, 0);
    check_eq("post_rst_sw_done", done_c, 2);
    check_eq("post_rst_sw_wdata", wd0, 32'h0123_4567);
    check_eq("post_rst_sw_err", {31'd0, err_r}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
